texture_loader: RTL and testbench

Load-side sequencer that copies the bird, pipe and ground textures from SDRAM into the sprite renderer's on-chip texture RAMs. It sits between the SDRAM read arbiter and the renderer's texture write ports, and runs in the 50 MHz `bird_load_clk` domain. It issues burst read requests and re-emits each returned word as a segment-local write strobe, address and data. It loads three segments in a fixed order (bird → pipe → base) and flags completion.

---
 rtl/texture_loader_if.sv | 29 ++
 rtl/texture_loader.sv | 187 ++++++++++++++++++
 tb/tb_texture_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/texture_loader_if.sv
// SDRAM read-request bus between the texture loader and the SDRAM read arbiter.
interface texture_loader_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [8:0]  rd_len;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;

  // Loader side: issues bursts, receives words.
  modport master (
    output rd_req,
    output rd_addr,
    output rd_len,
    input  rd_ack,
    input  rd_valid,
    input  rd_data
  );

  // Arbiter side: accepts bursts, returns words.
  modport slave (
    input  rd_req,
    input  rd_addr,
    input  rd_len,
    output rd_ack,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/texture_loader.sv
// Copies the bird, pipe and ground textures from SDRAM into the renderer's texture RAMs.
// Segments load in fixed order bird -> pipe -> base; each is fetched as bursts of up to
// BURST_LEN words, and every returned word becomes a one-cycle write strobe on that
// segment's RAM port.
module texture_loader #(
  parameter logic [23:0] BIRD_SDRAM_ADDR = 24'h000000,
  parameter int unsigned BIRD_WORDS      = 5250,
  parameter logic [23:0] PIPE_SDRAM_ADDR = 24'h002000,
  parameter int unsigned PIPE_WORDS      = 40000,
  parameter logic [23:0] BASE_SDRAM_ADDR = 24'h00C000,
  parameter int unsigned BASE_WORDS      = 9600,
  parameter int unsigned BURST_LEN       = 256
) (
  input  logic                    bird_load_clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  texture_loader_if.master        io_rd,
  output logic                    o_bird_load_en,
  output logic [12:0]             o_bird_load_addr,
  output logic [15:0]             o_bird_load_data,
  output logic                    o_pipe_load_en,
  output logic [15:0]             o_pipe_load_addr,
  output logic                    o_base_load_en,
  output logic [13:0]             o_base_load_addr,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam logic [15:0] BirdWords  = 16'(BIRD_WORDS);
  localparam logic [15:0] PipeWords  = 16'(PIPE_WORDS);
  localparam logic [15:0] BaseWords  = 16'(BASE_WORDS);
  localparam logic [15:0] BurstLen16 = 16'(BURST_LEN);
  localparam logic [8:0]  BurstLen9  = 9'(BURST_LEN);

  // Completion is flagged on the transition back to idle, so no separate done state.
  typedef enum logic [1:0] {StIdle, StReq, StData} state_e;
  typedef enum logic [1:0] {SegBird, SegPipe, SegBase} seg_e;

  state_e      r_state;
  seg_e        r_seg;
  logic [15:0] r_wcnt;
  logic [8:0]  r_bcnt;
  logic        r_rd_req;
  logic [23:0] r_rd_addr;
  logic [8:0]  r_rd_len;
  logic        r_bird_en;
  logic        r_pipe_en;
  logic        r_base_en;
  logic [12:0] r_bird_addr;
  logic [15:0] r_pipe_addr;
  logic [13:0] r_base_addr;
  logic [15:0] r_data;
  logic        r_busy;
  logic        r_done;

  function automatic logic [15:0] f_seg_words(input seg_e s);
    case (s)
      SegBird: return BirdWords;
      SegPipe: return PipeWords;
      default: return BaseWords;
    endcase
  endfunction

  function automatic logic [23:0] f_seg_base(input seg_e s);
    case (s)
      SegBird: return BIRD_SDRAM_ADDR;
      SegPipe: return PIPE_SDRAM_ADDR;
      default: return BASE_SDRAM_ADDR;
    endcase
  endfunction

  // Remaining words are below BURST_LEN (<= 256) on the short path, so 9 bits hold them.
  function automatic logic [8:0] f_burst_len(input logic [15:0] remain);
    if (remain >= BurstLen16) return BurstLen9;
    return remain[8:0];
  endfunction

  function automatic seg_e f_next_seg(input seg_e s);
    case (s)
      SegBird: return SegPipe;
      default: return SegBase;
    endcase
  endfunction

  // Sequencer: request/data handshake, per-segment word counting and write strobes.
  always_ff @(posedge bird_load_clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_seg       <= SegBird;
      r_wcnt      <= '0;
      r_bcnt      <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_bird_en   <= 1'b0;
      r_pipe_en   <= 1'b0;
      r_base_en   <= 1'b0;
      r_bird_addr <= '0;
      r_pipe_addr <= '0;
      r_base_addr <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_bird_en <= 1'b0;
      r_pipe_en <= 1'b0;
      r_base_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_seg     <= SegBird;
            r_wcnt    <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_rd_req  <= 1'b1;
            r_rd_addr <= BIRD_SDRAM_ADDR;
            r_rd_len  <= f_burst_len(BirdWords);
            r_state   <= StReq;
          end
        end
        StReq: begin
          // Address and length stay put until the arbiter accepts.
          if (io_rd.rd_ack) begin
            r_rd_req <= 1'b0;
            r_bcnt   <= r_rd_len;
            r_state  <= StData;
          end
        end
        StData: begin
          if (r_bcnt != '0) begin
            if (io_rd.rd_valid) begin
              r_data <= io_rd.rd_data;
              unique case (r_seg)
                SegBird: begin
                  r_bird_en   <= 1'b1;
                  r_bird_addr <= r_wcnt[12:0];
                end
                SegPipe: begin
                  r_pipe_en   <= 1'b1;
                  r_pipe_addr <= r_wcnt;
                end
                default: begin
                  r_base_en   <= 1'b1;
                  r_base_addr <= r_wcnt[13:0];
                end
              endcase
              r_wcnt <= r_wcnt + 16'd1;
              r_bcnt <= r_bcnt - 9'd1;
            end
          end else if (r_wcnt < f_seg_words(r_seg)) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= f_seg_base(r_seg) + {8'd0, r_wcnt};
            r_rd_len  <= f_burst_len(f_seg_words(r_seg) - r_wcnt);
            r_state   <= StReq;
          end else if (r_seg != SegBase) begin
            r_seg     <= f_next_seg(r_seg);
            r_wcnt    <= '0;
            r_rd_req  <= 1'b1;
            r_rd_addr <= f_seg_base(f_next_seg(r_seg));
            r_rd_len  <= f_burst_len(f_seg_words(f_next_seg(r_seg)));
            r_state   <= StReq;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_rd.rd_req     = r_rd_req;
  assign io_rd.rd_addr    = r_rd_addr;
  assign io_rd.rd_len     = r_rd_len;
  assign o_bird_load_en   = r_bird_en;
  assign o_bird_load_addr = r_bird_addr;
  assign o_bird_load_data = r_data;
  assign o_pipe_load_en   = r_pipe_en;
  assign o_pipe_load_addr = r_pipe_addr;
  assign o_base_load_en   = r_base_en;
  assign o_base_load_addr = r_base_addr;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: tb/tb_texture_loader.sv
// Bench for texture_loader: the bench plays the SDRAM arbiter with random ack delays, gaps and
// spurious valids, and a queue-based model predicts every request, strobe and status bit.
module tb_texture_loader;

  logic        bird_load_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        bird_en, pipe_en, base_en, busy, done;
  logic [12:0] bird_addr;
  logic [15:0] pipe_addr, load_data;
  logic [13:0] base_addr;

  texture_loader_if u_if ();

  texture_loader u_dut (
    .bird_load_clk    (bird_load_clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .io_rd            (u_if),
    .o_bird_load_en   (bird_en),
    .o_bird_load_addr (bird_addr),
    .o_bird_load_data (load_data),
    .o_pipe_load_en   (pipe_en),
    .o_pipe_load_addr (pipe_addr),
    .o_base_load_en   (base_en),
    .o_base_load_addr (base_addr),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #10 bird_load_clk = ~bird_load_clk;

  int seg_words [3] = '{5250, 40000, 9600};
  int seg_base  [3] = '{'h000000, 'h002000, 'h00C000};

  typedef struct { int seg; int woff; int len; int addr; } req_t;
  typedef struct { int due; int seg; int addr; logic [15:0] data; bit last; bit fin; } wr_t;

  req_t reqs[$];
  wr_t  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  bit rst_smp = 1'b0;
  int start_due = -1, req_due = -1, done_due = -1;

  // Model state owned by the compare process.
  bit         m_busy = 1'b0, m_done = 1'b0, in_req = 1'b0;
  int         req_idx = 0;
  int         last_addr [3] = '{0, 0, 0};
  int         n_wr [3] = '{0, 0, 0};
  logic [2:0] exp_en;
  wr_t        e;

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      if (n_fail >= 200) begin
        $display("FAIL abort: too many failures");
        summary();
        $fatal(1, "aborted");
      end
    end
  endtask

  always @(posedge bird_load_clk) begin
    cyc++;
    rst_smp = rst_n;
  end

  // Compare process: every cycle, outputs against the model.
  always @(negedge bird_load_clk) begin
    if (cyc > 0) begin
      if (!rst_smp) begin
        chk("rst_rd_req", u_if.rd_req, 0);
        chk("rst_rd_addr", u_if.rd_addr, 0);
        chk("rst_rd_len", u_if.rd_len, 0);
        chk("rst_load_en", {base_en, pipe_en, bird_en}, 0);
        chk("rst_bird_addr", bird_addr, 0);
        chk("rst_pipe_addr", pipe_addr, 0);
        chk("rst_base_addr", base_addr, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        in_req = 0; m_busy = 0; m_done = 0; req_idx = 0;
        last_addr = '{0, 0, 0};
        req_due = -1; done_due = -1; start_due = -1;
      end else begin
        exp_en = 3'b000;
        if (cyc == start_due) begin
          m_busy = 1; m_done = 0; in_req = 1; req_idx = 0;
        end
        if (cyc == req_due) in_req = 1;
        if (cyc == done_due) begin
          m_busy = 0; m_done = 1;
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          exp_en[e.seg] = 1'b1;
          last_addr[e.seg] = e.addr;
          n_wr[e.seg]++;
          chk("load_data", load_data, e.data);
          if (e.last) req_due = cyc + 1;
          if (e.fin) done_due = cyc + 1;
        end
        chk("load_en", {base_en, pipe_en, bird_en}, exp_en);
        chk("bird_addr", bird_addr, last_addr[0]);
        chk("pipe_addr", pipe_addr, last_addr[1]);
        chk("base_addr", base_addr, last_addr[2]);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("rd_req", u_if.rd_req, in_req);
        if (in_req && req_idx < reqs.size()) begin
          chk("rd_addr", u_if.rd_addr, reqs[req_idx].addr);
          chk("rd_len", u_if.rd_len, reqs[req_idx].len);
          if (u_if.rd_ack === 1'b1) begin
            req_idx++;
            in_req = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge bird_load_clk);
    #1;
  endtask

  task automatic pulse_start(input bit accepted);
    start = 1'b1;
    if (accepted) start_due = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  // Arbiter for request k: optional spurious valids, ack delay, gapped data, one extra valid.
  task automatic serve_burst(input int k, input int ack_delay, input int gap, input bit spur,
                             input int maxw);
    int   n;
    int   nw;
    req_t r;
    r = reqs[k];
    n = 0;
    while (u_if.rd_req !== 1'b1 && n < 64) begin
      u_if.rd_valid = spur ? 1'($urandom) : 1'b0;
      u_if.rd_data  = 16'($urandom);
      tick();
      n++;
    end
    u_if.rd_valid = 1'b0;
    chk("rd_req_wait", u_if.rd_req, 1);
    repeat (ack_delay) begin
      u_if.rd_ack   = 1'b0;
      u_if.rd_valid = spur ? 1'($urandom) : 1'b0;
      tick();
    end
    u_if.rd_ack   = 1'b1;
    u_if.rd_valid = spur ? 1'($urandom) : 1'b0;
    tick();
    u_if.rd_ack = 1'b0;
    nw = (maxw < r.len) ? maxw : r.len;
    for (int w = 0; w < nw; w++) begin
      if (gap == 1) begin
        u_if.rd_valid = 1'b0;
        repeat (2) tick();
      end else if (gap == 2 && $urandom_range(0, 7) == 0) begin
        u_if.rd_valid = 1'b0;
        tick();
      end
      u_if.rd_valid = 1'b1;
      u_if.rd_data  = 16'($urandom);
      exp_q.push_back('{cyc + 1, r.seg, r.woff + w, u_if.rd_data,
                        (w == r.len - 1) && (k != reqs.size() - 1),
                        (w == r.len - 1) && (k == reqs.size() - 1)});
      tick();
    end
    u_if.rd_valid = 1'b0;
    if (nw == r.len) begin
      // A word beyond the burst length must not produce a strobe.
      u_if.rd_valid = spur;
      u_if.rd_data  = 16'($urandom);
      tick();
      u_if.rd_valid = 1'b0;
    end
  endtask

  initial begin
    #(20 * 120000);
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "timeout");
  end

  initial begin
    int total;
    u_if.rd_ack = 1'b0;
    u_if.rd_valid = 1'b0;
    u_if.rd_data = '0;

    // Expected request sequence straight from segment sizes and burst limit.
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < seg_words[s]; w += 256) begin
        reqs.push_back('{s, w, (seg_words[s] - w > 256) ? 256 : seg_words[s] - w,
                         (seg_base[s] + w) & 'hFFFFFF});
      end
    end
    total = 0;
    foreach (reqs[i]) total += reqs[i].len;
    chk("model_req_count", reqs.size(), 216);
    chk("model_total_words", total, 54850);
    chk("model_bird_tail_len", reqs[20].len, 130);
    chk("model_bird_tail_addr", reqs[20].addr, 5120);
    chk("model_pipe_tail_len", reqs[177].len, 64);
    chk("model_base_first_addr", reqs[178].addr, 'h00C000);
    chk("model_base_tail_len", reqs[215].len, 128);

    // Reset with random inputs, then idle without start.
    repeat (6) begin
      start = 1'($urandom);
      u_if.rd_ack = 1'($urandom);
      u_if.rd_valid = 1'($urandom);
      u_if.rd_data = 16'($urandom);
      tick();
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (6) begin
      u_if.rd_ack = 1'($urandom);
      u_if.rd_valid = 1'($urandom);
      u_if.rd_data = 16'($urandom);
      tick();
    end
    u_if.rd_ack = 1'b0;
    u_if.rd_valid = 1'b0;

    // Full load: first burst back-pressured, two 1-in-3 bursts, random gaps elsewhere.
    pulse_start(1);
    for (int k = 0; k < 216; k++) begin
      if (k == 100) pulse_start(0);
      serve_burst(k, (k == 0) ? 7 : int'($urandom_range(0, 2)), (k == 1 || k == 2) ? 1 : 2,
                  (k % 4 == 3), 1 << 20);
    end
    repeat (4) tick();
    chk("bird_writes", n_wr[0], 5250);
    chk("pipe_writes", n_wr[1], 40000);
    chk("base_writes", n_wr[2], 9600);
    chk("total_writes", n_wr[0] + n_wr[1] + n_wr[2], 54850);
    chk("base_last_addr", base_addr, 9599);
    chk("done_after_load", done, 1);
    chk("busy_after_load", busy, 0);

    // Interrupted load: reset mid-burst with words still arriving, then reload.
    pulse_start(1);
    serve_burst(0, 0, 0, 1'b0, 1 << 20);
    serve_burst(1, 1, 0, 1'b1, 1 << 20);
    serve_burst(2, 0, 2, 1'b0, 100);
    rst_n = 1'b0;
    repeat (3) begin
      u_if.rd_valid = 1'b1;
      u_if.rd_data = 16'($urandom);
      tick();
    end
    rst_n = 1'b1;
    u_if.rd_valid = 1'b1;
    tick();
    u_if.rd_valid = 1'b0;
    repeat (3) tick();
    chk("done_cleared_by_reset", done, 0);
    pulse_start(1);
    serve_burst(0, 2, 2, 1'b1, 1 << 20);
    serve_burst(1, 0, 0, 1'b0, 50);
    repeat (3) tick();
    chk("done_low_during_reload", done, 0);
    chk("busy_during_reload", busy, 1);
    chk("reload_bird_addr", bird_addr, 305);

    summary();
    $finish;
  end

endmodule
